// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK flip-flop bank with up/down modulo counting and parallel load.
// Define JKREG_SATURATE_EN to make the count modes saturate instead of wrap.
module jk_counter_reg #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 2**WIDTH,
    parameter int RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Range compares use WIDTH+1 bits so MODULUS = 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_X  = MOD_X - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_Q  = MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             tc_s;

    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k
    );
        jk_next = (j & ~q) | (~k & q);
    endfunction

    function automatic logic [WIDTH-1:0] up_next(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] qx;
        qx = {1'b0, q};
`ifdef JKREG_SATURATE_EN
        if (qx >= MAX_X) begin
            up_next = MAX_Q;
        end else begin
            up_next = q + ONE_Q;
        end
`else
        if (qx >= MAX_X) begin
            up_next = ZERO_Q;
        end else begin
            up_next = q + ONE_Q;
        end
`endif
    endfunction

    function automatic logic [WIDTH-1:0] down_next(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] qx;
        qx = {1'b0, q};
`ifdef JKREG_SATURATE_EN
        if (qx >= MOD_X) begin
            down_next = MAX_Q;
        end else if (q == ZERO_Q) begin
            down_next = ZERO_Q;
        end else begin
            down_next = q - ONE_Q;
        end
`else
        if ((q == ZERO_Q) || (qx >= MOD_X)) begin
            down_next = MAX_Q;
        end else begin
            down_next = q - ONE_Q;
        end
`endif
    endfunction

    function automatic logic up_tc(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] qx;
        qx = {1'b0, q};
`ifdef JKREG_SATURATE_EN
        up_tc = (qx == MAX_X);
`else
        up_tc = (qx >= MAX_X);
`endif
    endfunction

    function automatic logic down_tc(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] qx;
        qx = {1'b0, q};
`ifdef JKREG_SATURATE_EN
        down_tc = (q == ZERO_Q);
`else
        down_tc = (q == ZERO_Q) || (qx >= MOD_X);
`endif
    endfunction

    // Next-state selection by mode; EN=0 holds in every mode.
    always_comb begin
        q_next_s = q_r;
        if (EN) begin
            case (MODE)
                MODE_JK:   q_next_s = jk_next(q_r, J, K);
                MODE_UP:   q_next_s = up_next(q_r);
                MODE_DOWN: q_next_s = down_next(q_r);
                MODE_LOAD: q_next_s = D;
                default:   q_next_s = q_r;
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Terminal-count flag: high when the next enabled edge wraps (or is saturated).
    always_comb begin
        tc_s = 1'b0;
        if (EN) begin
            case (MODE)
                MODE_UP:   tc_s = up_tc(q_r);
                MODE_DOWN: tc_s = down_tc(q_r);
                default:   tc_s = 1'b0;
            endcase
        end else begin
            tc_s = 1'b0;
        end
    end

    // State register with asynchronous reset to RESET_VALUE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_r <= RST_Q;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign Q  = q_r;
    assign QN = ~q_r;
    assign TC = tc_s;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Directed bench for jk_counter_reg (WIDTH=4, MODULUS=10, RESET_VALUE=0).
// Expectations follow JKREG_SATURATE_EN when the bench is built with it.
module tb_jk_counter_reg;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic [1:0] MODE;
    logic [3:0] J;
    logic [3:0] K;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] QN;
    logic       TC;

    int errors = 0;
    int checks = 0;

    jk_counter_reg #(
        .WIDTH(4),
        .MODULUS(10),
        .RESET_VALUE(0)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .EN(EN),
        .MODE(MODE),
        .J(J),
        .K(K),
        .D(D),
        .Q(Q),
        .QN(QN),
        .TC(TC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        EN = 1'b1;
        MODE = 2'b11;
        D = v;
        step();
        check_val("load_q", {28'd0, Q}, {28'd0, v});
    endtask

`ifdef JKREG_SATURATE_EN
    logic [3:0] up_exp [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    logic       up_tc  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] dn_exp [4]  = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       dn_tc  [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] oor_up_q    = 4'd9;
    logic       oor_up_tc   = 1'b0;
    logic       oor_dn_tc   = 1'b0;
`else
    logic [3:0] up_exp [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       up_tc  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] dn_exp [4]  = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       dn_tc  [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] oor_up_q    = 4'd0;
    logic       oor_up_tc   = 1'b1;
    logic       oor_dn_tc   = 1'b1;
`endif

    initial begin
        RESET = 1'b1;
        EN    = 1'b0;
        MODE  = 2'b00;
        J     = 4'h0;
        K     = 4'h0;
        D     = 4'h0;
        step();
        check_val("rst_q", {28'd0, Q}, 32'd0);
        check_val("rst_qn", {28'd0, QN}, 32'hF);
        check_val("rst_tc", {31'd0, TC}, 32'd0);
        RESET = 1'b0;

        // 1: async reset between edges from Q=7
        load(4'd7);
        EN = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check_val("async_rst_q", {28'd0, Q}, 32'd0);
        check_val("async_rst_qn", {28'd0, QN}, 32'hF);
        #1;
        RESET = 1'b0;
        D = 4'h5;
        step();
        check_val("rel_hold_q", {28'd0, Q}, 32'd0);

        // 2: JK bank
        load(4'b0011);
        MODE = 2'b00;
        J = 4'b1010;
        K = 4'b0110;
        step();
        check_val("jk_mix", {28'd0, Q}, 32'b1001);
        check_val("jk_tc", {31'd0, TC}, 32'd0);
        J = 4'hF;
        K = 4'hF;
        step();
        check_val("jk_toggle", {28'd0, Q}, 32'b0110);
        J = 4'h0;
        K = 4'h0;
        step();
        check_val("jk_hold", {28'd0, Q}, 32'b0110);

        // 3: count up 12 edges from 0
        load(4'd0);
        MODE = 2'b01;
        for (int i = 0; i < 12; i++) begin
            step();
            check_val($sformatf("up_q[%0d]", i), {28'd0, Q}, {28'd0, up_exp[i]});
            check_val($sformatf("up_tc[%0d]", i), {31'd0, TC}, {31'd0, up_tc[i]});
        end

        // 4: count down 4 edges from 2
        load(4'd2);
        MODE = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("dn_q[%0d]", i), {28'd0, Q}, {28'd0, dn_exp[i]});
            check_val($sformatf("dn_tc[%0d]", i), {31'd0, TC}, {31'd0, dn_tc[i]});
        end

        // 5: out-of-range values
        load(4'hC);
        check_val("load_tc", {31'd0, TC}, 32'd0);
        MODE = 2'b01;
        #1;
        check_val("oor_up_tc", {31'd0, TC}, {31'd0, oor_up_tc});
        step();
        check_val("oor_up_q", {28'd0, Q}, {28'd0, oor_up_q});
        load(4'hC);
        MODE = 2'b10;
        #1;
        check_val("oor_dn_tc", {31'd0, TC}, {31'd0, oor_dn_tc});
        step();
        check_val("oor_dn_q", {28'd0, Q}, 32'd9);

        // 6: EN=0 holds in every mode, then consecutive mode switch
        load(4'd5);
        EN = 1'b0;
        J = 4'hF;
        K = 4'h0;
        D = 4'hA;
        for (int m = 0; m < 4; m++) begin
            MODE = 2'(m);
            for (int e = 0; e < 3; e++) begin
                step();
                check_val($sformatf("en0_q[m%0d,%0d]", m, e), {28'd0, Q}, 32'd5);
                check_val($sformatf("en0_tc[m%0d,%0d]", m, e), {31'd0, TC}, 32'd0);
            end
        end
        EN = 1'b1;
        MODE = 2'b01;
        step();
        check_val("switch_up", {28'd0, Q}, 32'd6);
        MODE = 2'b10;
        step();
        check_val("switch_dn", {28'd0, Q}, 32'd5);

        // Reset mid-count, counting resumes from RESET_VALUE
        MODE = 2'b01;
        step();
        check_val("mid_q", {28'd0, Q}, 32'd6);
        #2;
        RESET = 1'b1;
        #1;
        check_val("mid_rst_q", {28'd0, Q}, 32'd0);
        #1;
        RESET = 1'b0;
        step();
        check_val("resume_q", {28'd0, Q}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
